// File: rtl/regs_sb.sv
// Parametrised register file with per-register busy scoreboard and running busy count.
// Optional same-cycle write-through forwarding is built when REGS_SB_BYPASS_EN is defined.
module regs_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     reg_Wt_addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    input  logic [ADDR_W-1:0]     reg_Rs_addr_A,
    input  logic [ADDR_W-1:0]     reg_Rt_addr_B,
    output logic [DATA_W-1:0]     rdata_A,
    output logic [DATA_W-1:0]     rdata_B,
    output logic                  busy_A,
    output logic                  busy_B,
    output logic [ADDR_W:0]       busy_cnt
);
    localparam int NREG = 2**ADDR_W;
    localparam int NB   = DATA_W/8;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W:0]   r_cnt;

    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [NB-1:0]     be);
        f_merge = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) f_merge[8*i +: 8] = new_w[8*i +: 8];
    endfunction

    // Gating with rst keeps the bypass path quiet while reset is held.
    logic w_wr_vld, w_rsv_vld, w_rsv_hit, w_set, w_clr;
    assign w_wr_vld  = rst & we & (reg_Wt_addr != '0);
    assign w_rsv_vld = rst & rsv_en & (rsv_addr != '0);
    assign w_rsv_hit = w_rsv_vld & (rsv_addr == reg_Wt_addr);
    assign w_set     = w_rsv_vld & ~r_busy[rsv_addr];
    assign w_clr     = w_wr_vld & r_busy[reg_Wt_addr] & ~w_rsv_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_vld) begin
                r_mem[reg_Wt_addr]  <= f_merge(r_mem[reg_Wt_addr], wdata, wbe);
                r_busy[reg_Wt_addr] <= 1'b0;
            end
            // Later assignment lets a same-cycle reserve win over the clear.
            if (w_rsv_vld) r_busy[rsv_addr] <= 1'b1;
            r_cnt <= r_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr);
        end
    end

    logic [DATA_W-1:0] w_st_a, w_st_b;
    assign w_st_a = (reg_Rs_addr_A == '0) ? '0 : r_mem[reg_Rs_addr_A];
    assign w_st_b = (reg_Rt_addr_B == '0) ? '0 : r_mem[reg_Rt_addr_B];

`ifdef REGS_SB_BYPASS_EN
    logic w_byp_a, w_byp_b;
    assign w_byp_a = w_wr_vld & (reg_Rs_addr_A == reg_Wt_addr);
    assign w_byp_b = w_wr_vld & (reg_Rt_addr_B == reg_Wt_addr);
    assign rdata_A = w_byp_a ? f_merge(w_st_a, wdata, wbe) : w_st_a;
    assign rdata_B = w_byp_b ? f_merge(w_st_b, wdata, wbe) : w_st_b;
    assign busy_A  = w_byp_a ? w_rsv_hit : r_busy[reg_Rs_addr_A];
    assign busy_B  = w_byp_b ? w_rsv_hit : r_busy[reg_Rt_addr_B];
`else
    assign rdata_A = w_st_a;
    assign rdata_B = w_st_b;
    assign busy_A  = r_busy[reg_Rs_addr_A];
    assign busy_B  = r_busy[reg_Rt_addr_B];
`endif

    assign busy_cnt = r_cnt;

endmodule

// File: tb/tb_regs_sb.sv
// Scoreboard bench for regs_sb: driver pushes model expectations, monitor pops and compares.
module tb_regs_sb;
    logic        clk = 1'b0;
    logic        rst, we, rsv_en;
    logic [3:0]  wbe;
    logic [4:0]  reg_Wt_addr, rsv_addr, reg_Rs_addr_A, reg_Rt_addr_B;
    logic [31:0] wdata, rdata_A, rdata_B;
    logic        busy_A, busy_B;
    logic [5:0]  busy_cnt;

    regs_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .reg_Wt_addr(reg_Wt_addr),
        .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .reg_Rs_addr_A(reg_Rs_addr_A), .reg_Rt_addr_B(reg_Rt_addr_B),
        .rdata_A(rdata_A), .rdata_B(rdata_B), .busy_A(busy_A), .busy_B(busy_B),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        ba, bb;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_mem [32];
    logic        m_busy [32];
    int          n_pass = 0, n_tot = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] v = o;
        for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = n[8*i +: 8];
        return v;
    endfunction

    function automatic logic [5:0] count_busy();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 6'(c);
    endfunction

    function automatic logic [31:0] rd_val(input logic [4:0] ad);
        logic [31:0] v = m_mem[ad];
`ifdef REGS_SB_BYPASS_EN
        if (rst && we && reg_Wt_addr != 0 && ad == reg_Wt_addr) v = merge(v, wdata, wbe);
`endif
        return v;
    endfunction

    function automatic logic rd_busy(input logic [4:0] ad);
        logic b = m_busy[ad];
`ifdef REGS_SB_BYPASS_EN
        if (rst && we && reg_Wt_addr != 0 && ad == reg_Wt_addr)
            b = rsv_en && rsv_addr == ad;
`endif
        return b;
    endfunction

    // Drive one cycle of stimulus, record what the outputs must show, then advance the model.
    task automatic cyc(input logic r, input logic w, input logic [3:0] be, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rv, input logic [4:0] ra,
                       input logic [4:0] aa, input logic [4:0] ab);
        exp_t e;
        @(posedge clk); #2;
        rst = r; we = w; wbe = be; reg_Wt_addr = wa; wdata = wd;
        rsv_en = rv; rsv_addr = ra; reg_Rs_addr_A = aa; reg_Rt_addr_B = ab;
        if (!r) for (int i = 0; i < 32; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
        e.a = rd_val(aa); e.b = rd_val(ab);
        e.ba = rd_busy(aa); e.bb = rd_busy(ab);
        e.cnt = count_busy();
        q.push_back(e);
        if (r) begin
            if (w && wa != 0) begin m_mem[wa] = merge(m_mem[wa], wd, be); m_busy[wa] = 0; end
            if (rv && ra != 0) m_busy[ra] = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata_A", rdata_A, e.a);
                chk("rdata_B", rdata_B, e.b);
                chk("busy_A", 32'(busy_A), 32'(e.ba));
                chk("busy_B", 32'(busy_B), 32'(e.bb));
                chk("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        int guard;
        rst = 0; we = 0; wbe = 0; reg_Wt_addr = 0; wdata = 0; rsv_en = 0; rsv_addr = 0;
        reg_Rs_addr_A = 0; reg_Rt_addr_B = 0;
        for (int i = 0; i < 32; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
        repeat (2) cyc(0, 0, 4'h0, 0, 0, 0, 0, 5, 6);
        // Basic write/read
        cyc(1, 1, 4'hF, 5, 32'hA5A5A5A5, 0, 0, 5, 6);
        cyc(1, 1, 4'hF, 6, 32'h55AA55AA, 0, 0, 5, 6);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 5, 6);
        // Register 0 write and reserve are ignored
        cyc(1, 1, 4'hF, 0, 32'hAAAA5555, 1, 0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 0, 5);
        // Byte enables
        cyc(1, 1, 4'b0101, 5, 32'h11223344, 0, 0, 5, 6);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 5, 6);
        // Scoreboard
        cyc(1, 0, 4'h0, 0, 0, 1, 3, 3, 4);
        cyc(1, 0, 4'h0, 0, 0, 1, 4, 3, 4);
        cyc(1, 0, 4'h0, 0, 0, 1, 4, 3, 4);
        cyc(1, 1, 4'hF, 3, 32'h33333333, 0, 0, 3, 4);
        cyc(1, 1, 4'hF, 7, 32'h77777777, 0, 0, 3, 7);
        cyc(1, 1, 4'h0, 4, 32'h0, 0, 0, 3, 4);
        cyc(1, 0, 4'h0, 0, 0, 1, 4, 3, 4);
        // Same-cycle write and reserve to busy register 4
        cyc(1, 1, 4'hF, 4, 32'h44440000, 1, 4, 4, 4);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 3, 4);
        // Write 9 while reading it
        cyc(1, 1, 4'hF, 9, 32'hDEADBEEF, 0, 0, 9, 9);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 9, 4);
        // Reset mid-operation with register 9 busy and a write pending
        cyc(1, 0, 4'h0, 0, 0, 1, 9, 9, 4);
        cyc(0, 1, 4'hF, 9, 32'h12345678, 1, 9, 9, 4);
        cyc(0, 0, 4'h0, 0, 0, 0, 0, 9, 5);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 9, 5);
        // Randomized traffic on a narrow address range for frequent collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra, aa, ab;
            wa = 5'($urandom_range(0, 9)); ra = 5'($urandom_range(0, 9));
            aa = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 9));
            ab = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
            if (n % 37 == 0) begin wa = 5'($urandom); ra = 5'($urandom); end
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), 4'($urandom), wa,
                $urandom, ($urandom_range(0, 4) < 2), ra, aa, ab);
        end
        // Fill every register busy to reach the maximum count
        for (int i = 1; i < 32; i++) cyc(1, 0, 4'h0, 0, 0, 1, 5'(i), 5'(i), 0);
        cyc(1, 0, 4'h0, 0, 0, 1, 31, 31, 0);
        cyc(1, 0, 4'h0, 0, 0, 0, 0, 1, 31);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin @(posedge clk); guard++; end
        @(negedge clk); #1;
        if (q.size() > 0) begin
            n_tot++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/regs_sb.md
# regs_sb

Parametrised register file with a per-register scoreboard; it is the next-generation successor to the fixed 32×32 `Regs` block. It provides two combinational read ports, one byte-enabled write port and a reserve port. Each register carries a busy bit that marks an in-flight producer. Busy bits are set at issue and cleared at write-back, and a running busy count is maintained. The block sits between decode/issue and write-back in the CPU datapath.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits; must be a multiple of 8.
- `ADDR_W`, 5, address width; the file holds `2**ADDR_W` registers.

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — reset; asynchronous, active-low.
- `we` input 1 — write enable.
- `wbe` input `DATA_W/8` — byte enables for the write; bit i covers `wdata[8i+7:8i]`.
- `reg_Wt_addr` input `ADDR_W` — write address.
- `wdata` input `DATA_W` — write data.
- `rsv_en` input 1 — reserve request; marks the destination busy.
- `rsv_addr` input `ADDR_W` — register to reserve.
- `reg_Rs_addr_A` input `ADDR_W` — read address, port A.
- `reg_Rt_addr_B` input `ADDR_W` — read address, port B.
- `rdata_A` output `DATA_W` — read data, port A.
- `rdata_B` output `DATA_W` — read data, port B.
- `busy_A` output 1 — busy bit of the register addressed on port A.
- `busy_B` output 1 — busy bit of the register addressed on port B.
- `busy_cnt` output `ADDR_W+1` — number of registers currently busy.

## Operation
- Register 0:
  - Reads always return 0, and its busy bit is always 0.
  - Writes to it are ignored, and reserves of it are ignored.
- Write:
  - Occurs on a rising `clk` when `we` is 1 and `reg_Wt_addr` is not 0.
  - Only the bytes whose `wbe` bit is 1 are updated; all other bytes hold.
  - `we` with `wbe` equal to 0 updates no data but still clears the busy bit.
- Reserve: on a rising `clk` when `rsv_en` is 1 and `rsv_addr` is not 0, the busy bit of `rsv_addr` is set.
- Busy clear: a write to address a clears busy[a], unless a reserve of the same a occurs in the same cycle.
- Simultaneous write and reserve to the same address: reserve wins. Data is written and busy[a] ends at 1, because a new producer has been issued.
- `busy_cnt` is updated every cycle as `busy_cnt + set − clr`, where:
  - set = 1 only if the reserve is valid and the target was not busy;
  - clr = 1 only if the write is valid, the target was busy, and the target is not re-reserved in the same cycle.
  - Re-reserving an already-busy register changes nothing.
  - Writing a non-busy register changes nothing.
  - `busy_cnt` never exceeds `2**ADDR_W − 1`.
- Reads: `rdata_A/B` and `busy_A/B` are a combinational function of the addresses and the stored state. Both ports may address the same register.

## Timing
- Reset (`rst` = 0), asynchronous and taking effect immediately:
  - all registers are 0, all busy bits are 0, `busy_cnt` is 0;
  - `rdata_A` and `rdata_B` are 0, `busy_A` and `busy_B` are 0.
- Reset asserted mid-operation overrides any write or reserve in that cycle. Release is sampled at the next rising edge.
- Write-to-read latency:
  - One cycle without the bypass: written data and the busy clear are visible after the edge.
  - Zero cycles with the bypass; see Configuration.
- Reserve-to-busy latency: one cycle; `busy_A/B` goes high after the edge.
- `busy_cnt` reflects the state after each edge, with no combinational path from the inputs.

## Configuration
`REGS_SB_BYPASS_EN` controls write-through forwarding.

When it is defined, a read port whose address matches a valid write (`we` = 1, `reg_Wt_addr` not 0) in the same cycle behaves as follows:
- Its `rdata` returns the stored word with the `wbe`-enabled bytes replaced by `wdata`.
- Its `busy` returns 0, unless `rsv_en` targets the same address in that cycle.

When it is undefined, reads return stored state only, so a write becomes visible one cycle later. The bypass logic is not built.

## Test plan
- Reset and basic write/read:
  - Assert `rst` = 0 → all outputs are 0.
  - Release reset, then write 5 = 0xA5A5A5A5 and 6 = 0x55AA55AA with `wbe` = 0xF.
  - Read A = 5, B = 6 → 0xA5A5A5A5 and 0x55AA55AA.
- Register 0:
  - Write 0 = 0xAAAA5555 and reserve 0.
  - Read A = 0 → `rdata_A` = 0, `busy_A` = 0, `busy_cnt` unchanged.
- Byte enables: register 5 holds 0xA5A5A5A5; write 0x11223344 with `wbe` = 0b0101 → register 5 reads 0xA522A544.
- Scoreboard:
  - Reserve 3, 4 and 4 on consecutive cycles → `busy_cnt` = 2.
  - Write 3 → `busy_A`(3) = 0 and `busy_cnt` = 1.
  - Write 7 (not busy) → `busy_cnt` stays 1.
- Same-cycle write and reserve to busy register 4 → data is updated, `busy_B`(4) = 1, `busy_cnt` = 1.
- Bypass, with `REGS_SB_BYPASS_EN` defined:
  - Write 9 = 0xDEADBEEF while reading A = 9 in the same cycle → `rdata_A` = 0xDEADBEEF before the edge.
  - Without the macro → the old value before the edge, and 0xDEADBEEF after it.
- Reset mid-operation: assert `rst` low while register 9 is busy and a write is pending → everything is 0 immediately, and the write is lost.
